ps2_packet_sequencer: RTL
=========================

Name: ps2_packet_sequencer

Overview:
Sequences validated PS/2 mouse bytes from the receiver into complete movement packets for the downstream signal-mapping block. Tracks byte position with an FSM, enforces the byte-1 sync bit and an inter-byte timeout, and presents a registered, atomically updated packet plus a one-cycle valid strobe. Sits between the PS/2 frame receiver/validator and the mouse signal mapper.

Parameters:
TIMEOUT_CYCLES, 200000, max idle cycles between bytes of one packet before the partial packet is dropped (2 ms at 100 MHz); must be >= 2
ERR_W, 8, width of the saturating error counter

Ports:
i_clk  input  1  system clock
i_reset  input  1  asynchronous, active-high reset
i_stream_en  input  1  1 = streaming mode, assemble packets; 0 = command/config phase, bytes ignored
i_byte_valid  input  1  one-cycle strobe: i_byte holds a validated byte
i_byte  input  8  received byte
o_signal1  output  8  packet byte 1 (status/sync byte)
o_signal2  output  8  packet byte 2 (X)
o_signal3  output  8  packet byte 3 (Y)
o_signal4  output  8  packet byte 4 (wheel); 0 when the wheel feature is compiled out
o_packet_valid  output  1  one-cycle pulse when o_signal1..4 update
o_resync  output  1  one-cycle pulse when a byte or partial packet is discarded
o_busy  output  1  1 while a packet is partially assembled (state != WAIT_B1)
o_err_count  output  ERR_W  saturating count of discard events

Behaviour:
- Reset (async, immediate): state WAIT_B1; o_signal1..4 = 0; o_packet_valid, o_resync, o_busy = 0; o_err_count = 0; timeout counter = 0; staging registers = 0.
- States: WAIT_B1, WAIT_B2, WAIT_B3, WAIT_B4 (wheel build only). Bytes are captured into internal staging registers; outputs never show partial packets.
- WAIT_B1: on i_byte_valid with i_byte[3]=1 -> stage byte 1, go WAIT_B2. With i_byte[3]=0 -> discard, pulse o_resync, increment o_err_count, stay.
- WAIT_B2: byte -> stage byte 2, go WAIT_B3.
- WAIT_B3: byte -> stage byte 3; 3-byte build: commit, go WAIT_B1; wheel build: go WAIT_B4.
- WAIT_B4: byte -> stage byte 4, commit, go WAIT_B1.
- Commit: at the edge sampling the last byte, o_signal1..4 load staged values (last byte taken directly from i_byte) and o_packet_valid goes high for exactly the following cycle. Latency: last byte strobe -> o_packet_valid = 1 cycle. Outputs hold until the next commit.
- Back-to-back: a byte-1 strobe in the cycle immediately after a commit is accepted normally (no dead cycle).
- Timeout: counter clears on every accepted byte and counts while in WAIT_B2..B4 with no strobe. When it reaches TIMEOUT_CYCLES-1 with no strobe that cycle -> drop staged data, go WAIT_B1, pulse o_resync, increment o_err_count. A strobe in the expiry cycle wins: byte accepted, no timeout.
- i_stream_en = 0: FSM forced to WAIT_B1 next edge, strobes ignored, no error counted. Deassertion mid-packet drops the partial packet silently (no o_resync). Outputs hold last committed packet.
- o_err_count saturates at 2^ERR_W-1; never wraps.
- o_packet_valid and o_resync are never high in the same cycle.
- o_busy is registered state decode.

Optional Feature:
PS2_WHEEL_EN: defined -> 4-byte IntelliMouse packets, WAIT_B4 exists, o_signal4 carries byte 4. Undefined -> 3-byte packets, no WAIT_B4 logic, o_signal4 tied to 8'h00.

Test Plan:
- Reset mid-packet: bytes 08,05 then assert i_reset -> all outputs 0, o_busy=0 immediately; next packet 09,10,F0 commits cleanly.
- Normal 3-byte (feature off): strobes 09,10,F0 spaced 3 cycles -> 1 cycle after F0, o_packet_valid=1 for 1 cycle, o_signal1..4 = 09,10,F0,00; o_err_count=0.
- Bad sync: byte 00 in WAIT_B1 -> o_resync pulse, o_err_count=1, FSM stays WAIT_B1; following 08,01,02 commits 08,01,02.
- Timeout with TIMEOUT_CYCLES=16: 08,05 then 16 idle cycles -> o_resync at expiry, o_err_count=1, o_busy=0; strobe landing exactly in expiry cycle instead -> accepted, no resync.
- Stream disable: 08 then i_stream_en=0 for 2 cycles, re-enable -> no resync, no error, previous outputs held; bytes 0A,01,01 commit.
- Wheel (PS2_WHEEL_EN): 08,01,02,FF -> commit after 4th byte, o_signal4=FF; back-to-back next byte-1 in the cycle after commit accepted; 300 bad-sync bytes with ERR_W=8 -> o_err_count=255.

Source files
------------

// File: rtl/ps2_packet_sequencer.sv
// ps2_packet_sequencer: assembles validated PS/2 mouse bytes into packets.
// Define PS2_WHEEL_EN for 4-byte IntelliMouse packets (default: 3-byte).
module ps2_packet_sequencer #(
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int ERR_W          = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_stream_en,
  input  logic             i_byte_valid,
  input  logic [7:0]       i_byte,
  output logic [7:0]       o_signal1,
  output logic [7:0]       o_signal2,
  output logic [7:0]       o_signal3,
  output logic [7:0]       o_signal4,
  output logic             o_packet_valid,
  output logic             o_resync,
  output logic             o_busy,
  output logic [ERR_W-1:0] o_err_count
);

  localparam logic [1:0] WAIT_B1 = 2'd0;
  localparam logic [1:0] WAIT_B2 = 2'd1;
  localparam logic [1:0] WAIT_B3 = 2'd2;
`ifdef PS2_WHEEL_EN
  localparam logic [1:0] WAIT_B4 = 2'd3;
  localparam logic [1:0] LAST_ST = WAIT_B4;
`else
  localparam logic [1:0] LAST_ST = WAIT_B3;
`endif

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ?
                         $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] to_cnt;
  logic [7:0]       stg1;
  logic [7:0]       stg2;
`ifdef PS2_WHEEL_EN
  logic [7:0]       stg3;
`endif
  logic             take;
  logic             bad_sync;
  logic             expire;
  logic             commit;
  logic             discard;
  logic             drop;

  assign take     = i_stream_en & i_byte_valid;
  assign bad_sync = take & (state == WAIT_B1) & ~i_byte[3];
  assign expire   = i_stream_en & ~i_byte_valid &
                    (state != WAIT_B1) & (to_cnt == TO_LAST);
  assign commit   = take & (state == LAST_ST);
  assign discard  = bad_sync | expire;
  // Partial packets vanish on timeout or when streaming is switched off.
  assign drop     = expire | ~i_stream_en;
  assign o_busy   = (state != WAIT_B1);

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      !i_stream_en: state_nxt = WAIT_B1;
      expire:       state_nxt = WAIT_B1;
      take: begin
        case (state)
          WAIT_B1: state_nxt = i_byte[3] ? WAIT_B2 : WAIT_B1;
          WAIT_B2: state_nxt = WAIT_B3;
`ifdef PS2_WHEEL_EN
          WAIT_B3: state_nxt = WAIT_B4;
`else
          WAIT_B3: state_nxt = WAIT_B1;
`endif
          default: state_nxt = WAIT_B1;
        endcase
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state  <= WAIT_B1;
      to_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (take || state_nxt == WAIT_B1)
        to_cnt <= '0;
      else
        to_cnt <= to_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      stg1 <= 8'h00;
      stg2 <= 8'h00;
`ifdef PS2_WHEEL_EN
      stg3 <= 8'h00;
`endif
    end else if (drop) begin
      stg1 <= 8'h00;
      stg2 <= 8'h00;
`ifdef PS2_WHEEL_EN
      stg3 <= 8'h00;
`endif
    end else if (take) begin
      if (state == WAIT_B1 && i_byte[3])
        stg1 <= i_byte;
      if (state == WAIT_B2)
        stg2 <= i_byte;
`ifdef PS2_WHEEL_EN
      if (state == WAIT_B3)
        stg3 <= i_byte;
`endif
    end
  end

  // Last byte bypasses staging so the packet lands on the same edge.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_signal1 <= 8'h00;
      o_signal2 <= 8'h00;
      o_signal3 <= 8'h00;
`ifdef PS2_WHEEL_EN
      o_signal4 <= 8'h00;
`endif
    end else if (commit) begin
      o_signal1 <= stg1;
      o_signal2 <= stg2;
`ifdef PS2_WHEEL_EN
      o_signal3 <= stg3;
      o_signal4 <= i_byte;
`else
      o_signal3 <= i_byte;
`endif
    end
  end

`ifndef PS2_WHEEL_EN
  assign o_signal4 = 8'h00;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_packet_valid <= 1'b0;
      o_resync       <= 1'b0;
      o_err_count    <= '0;
    end else begin
      o_packet_valid <= commit;
      o_resync       <= discard;
      if (discard && o_err_count != ERR_MAX)
        o_err_count <= o_err_count + ERR_W'(1);
    end
  end

endmodule
